timer_multi: RTL and testbench
==============================

Name: timer_multi

Overview:
Parametrised N-channel down-counting timer; successor to the single-channel 32-bit periodic timer.
- Each channel runs one-shot or periodic with a per-channel period latched at start.
- Each channel emits a one-cycle tick at expiry and sets a sticky pending flag.
- Pending flags are ORed into one irq line for the interrupt controller.

Parameters:
N_CH, 4, number of independent timer channels (1..32)
WIDTH, 32, counter and period width in bits (2..64)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  N_CH  per-channel start/restart pulse
stop  in  N_CH  per-channel stop pulse
mode  in  N_CH  per-channel mode sampled at start: 0 = one-shot, 1 = periodic
period  in  N_CH*WIDTH  per-channel period, channel i at bits [i*WIDTH +: WIDTH], sampled at start
pause  in  1  global freeze of all counters
clr_pending  in  N_CH  write-1-to-clear for pending flags
tick  out  N_CH  one-cycle expiry pulse per channel
running  out  N_CH  channel is counting (including while paused)
pending  out  N_CH  sticky expiry flag per channel
irq  out  1  OR of pending

Behaviour:
- Reset (rst = 1 at an edge):
  - All counters = 0; state IDLE.
  - tick, running, pending, irq = 0.
  - Latched period and mode = 0.
  - Reset overrides every other input and may arrive mid-count.
- Per-channel states: IDLE, RUN.
- IDLE, start = 1:
  - Latch P = period[i] and M = mode[i].
  - Counter <= P-1, with P = 0 treated as P = 1.
  - Go to RUN; running = 1.
- RUN, pause = 0, counter != 0: counter decrements by 1.
- RUN, pause = 1: counter and state hold; no tick is produced.
- RUN, pause = 0, counter == 0 (expiry):
  - tick = 1 for exactly one cycle; pending <= 1.
  - M = 1: counter <= P-1, stay in RUN.
  - M = 0: go to IDLE; running <= 0 on the same edge.
- Latency: with start sampled at edge E0 and no pause, tick is high in the cycle after edge E0+P. Periodic ticks follow every P cycles. P = 1 gives a tick every cycle.
- start while in RUN: reload counter <= period-1 with fresh P and M. This is a restart; any expiry on the same edge is suppressed (no tick).
- stop = 1: go to IDLE, counter <= 0, no tick on that edge. Stop has priority over start and over expiry on the same edge.
- pause does not block start or stop.
- Pending flag:
  - Set on tick.
  - Cleared by clr_pending[i] = 1.
  - If set and clear occur on the same edge, set wins (no lost event).
- irq = |pending, registered; it follows pending with zero added latency.
- Counter arithmetic is modulo 2^WIDTH. No wrap below 0 is possible because expiry is checked at 0.
- The period input is don't-care except on edges where start is sampled.

Optional Feature:
Macro TIMER_MULTI_PRESCALE_EN.
- Defined:
  - Adds a parameter PRESC_W (default 16) and an input prescale [PRESC_W-1:0].
  - A shared free-running prescaler produces an enable every prescale+1 cycles; counters decrement only on enable cycles.
  - prescale = 0 behaves identically to the undefined build.
  - The prescaler resets to 0 on rst and is frozen by pause.
- Undefined: the port and parameter are absent; counters step every non-paused cycle.

Decomposition:
- Package timer_multi_pkg holds:
  - MODE_ONESHOT = 1'b0 and MODE_PERIODIC = 1'b1.
  - The channel state encoding (IDLE = 0, RUN = 1).
  - Default WIDTH and PRESC_W constants.
- Sub-module timer_channel: one channel (counter, latched P/M, state, tick, pending), instantiated N_CH times by a generate loop.
- The top level holds the prescaler, irq reduction and port slicing.

Test Plan:
- Reset, then start[0] with mode = 1, period = 5 -> tick[0] high one cycle at 5, 10 and 15 cycles after start; running[0] stays 1.
- One-shot on ch1, period = 3 -> single tick 3 cycles after start; running[1] falls on the tick edge; pending[1] = 1 and irq = 1 until clr_pending[1].
- Periodic period = 4 with pause held 3 cycles mid-count -> next tick delayed by exactly 3 cycles.
- stop and start on the same edge while running -> channel IDLE, no tick; start alone at counter == 0 -> reload, no tick.
- period = 0 and period = 1, periodic -> tick every cycle. Tick and clr_pending on the same edge -> pending remains 1.
- rst asserted mid-count on all channels -> all outputs 0 next cycle; no tick until a new start.

Source files
------------

// File: rtl/timer_multi_pkg.sv
// Shared constants and types for the multi-channel down-counting timer.
package timer_multi_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int DEF_N_CH    = 4;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_PRESC_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/timer_multi_if.sv
// Control/status bundle of timer_multi. The master drives the control
// vectors, the timer (slave) returns tick/running/pending/irq.
interface timer_multi_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 32
);
    logic [N_CH-1:0]       start;
    logic [N_CH-1:0]       stop;
    logic [N_CH-1:0]       mode;
    logic [N_CH*WIDTH-1:0] period;
    logic                  pause;
    logic [N_CH-1:0]       clr_pending;
    logic [N_CH-1:0]       tick;
    logic [N_CH-1:0]       running;
    logic [N_CH-1:0]       pending;
    logic                  irq;

    modport master (
        output start, stop, mode, period, pause, clr_pending,
        input  tick, running, pending, irq
    );

    modport slave (
        input  start, stop, mode, period, pause, clr_pending,
        output tick, running, pending, irq
    );
endinterface

// File: rtl/timer_channel.sv
// One timer channel: latched period/mode, down counter, expiry tick and
// sticky pending flag. step is the shared "count this cycle" qualifier
// (already folds in pause and the optional prescaler).
module timer_channel
    import timer_multi_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic             step,
    input  logic             clr,
    output logic             tick,
    output logic             running,
    output logic             pending,
    output logic             pend_nxt
);

    ch_state_e        state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] p_lat;
    logic             m_lat;
    logic             expire;

    // A period of 0 behaves like 1, so both reload to 0.
    function automatic logic [WIDTH-1:0] reload_of(input logic [WIDTH-1:0] p);
        return (p == '0) ? '0 : p - WIDTH'(1);
    endfunction

    // Expiry is suppressed by stop and by a restart on the same edge; a
    // new expiry wins over a simultaneous clear so no event is lost.
    always_comb begin
        expire   = (state == ST_RUN) && step && (cnt == '0) && !stop && !start;
        pend_nxt = expire | (pending & ~clr);
    end

    assign running = (state == ST_RUN);

    // Channel state machine: stop > start/restart > count/expire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            p_lat   <= '0;
            m_lat   <= MODE_ONESHOT;
            tick    <= 1'b0;
            pending <= 1'b0;
        end else begin
            tick    <= expire;
            pending <= pend_nxt;
            if (stop) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (start) begin
                state <= ST_RUN;
                p_lat <= period;
                m_lat <= mode;
                cnt   <= reload_of(period);
            end else if (state == ST_RUN && step) begin
                if (cnt == '0) begin
                    if (m_lat == MODE_PERIODIC) begin
                        cnt <= reload_of(p_lat);
                    end else begin
                        state <= ST_IDLE;
                    end
                end else begin
                    cnt <= cnt - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/timer_multi.sv
// N-channel down-counting timer with per-channel one-shot/periodic mode,
// expiry ticks, sticky pending flags and a combined irq.
// Optional build macro TIMER_MULTI_PRESCALE_EN adds a shared prescaler
// (parameter PRESC_W, input prescale) that gates counting to one cycle
// in every prescale+1.
module timer_multi
    import timer_multi_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH
`ifdef TIMER_MULTI_PRESCALE_EN
    ,
    parameter int PRESC_W = DEF_PRESC_W
`endif
) (
    input  logic               clk,
    input  logic               rst,
`ifdef TIMER_MULTI_PRESCALE_EN
    input  logic [PRESC_W-1:0] prescale,
`endif
    timer_multi_if.slave       bus
);

    logic            presc_en;
    logic            step;
    logic            irq_q;
    logic [N_CH-1:0] tick_v;
    logic [N_CH-1:0] run_v;
    logic [N_CH-1:0] pend_v;
    logic [N_CH-1:0] pend_nxt_v;

`ifdef TIMER_MULTI_PRESCALE_EN
    logic [PRESC_W-1:0] presc_cnt;

    // >= rather than == so a prescale lowered mid-count cannot strand the
    // counter above the new terminal value.
    assign presc_en = (presc_cnt >= prescale);

    // Free-running prescaler, frozen together with the counters by pause.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (!bus.pause) begin
            presc_cnt <= presc_en ? '0 : presc_cnt + PRESC_W'(1);
        end
    end
`else
    assign presc_en = 1'b1;
`endif

    assign step = presc_en & ~bus.pause;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .start    (bus.start[i]),
            .stop     (bus.stop[i]),
            .mode     (bus.mode[i]),
            .period   (bus.period[i*WIDTH +: WIDTH]),
            .step     (step),
            .clr      (bus.clr_pending[i]),
            .tick     (tick_v[i]),
            .running  (run_v[i]),
            .pending  (pend_v[i]),
            .pend_nxt (pend_nxt_v[i])
        );
    end

    // irq is registered from next-state pending so it lines up with pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |pend_nxt_v;
        end
    end

    assign bus.tick    = tick_v;
    assign bus.running = run_v;
    assign bus.pending = pend_v;
    assign bus.irq     = irq_q;

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: directed scenarios plus random
// stimulus, all compared every cycle against a remaining-cycles model.
module tb_timer_multi;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    timer_multi_if #(.N_CH(N), .WIDTH(W)) bus ();

`ifdef TIMER_MULTI_PRESCALE_EN
    logic [15:0] prescale = '0;
    timer_multi #(.N_CH(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .prescale(prescale), .bus(bus.slave));
`else
    timer_multi #(.N_CH(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: cycles left until expiry per active channel.
    bit           act  [N];
    int           left [N];
    int           per_m[N];
    bit           mod_m[N];
    logic [N-1:0] tick_m, run_m, pend_m;
    logic         irq_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input logic [N-1:0] st, input logic [N-1:0] sp,
                              input logic [N-1:0] md, input logic [N*W-1:0] per,
                              input bit pz, input logic [N-1:0] cl);
        for (int i = 0; i < N; i++) begin
            tick_m[i] = 1'b0;
            if (r) begin
                act[i] = 0; left[i] = 0; pend_m[i] = 1'b0;
            end else begin
                if (sp[i]) begin
                    act[i] = 0;
                end else if (st[i]) begin
                    act[i]   = 1;
                    per_m[i] = int'(per[i*W +: W]);
                    mod_m[i] = md[i];
                    left[i]  = (per_m[i] == 0) ? 1 : per_m[i];
                end else if (act[i] && !pz) begin
                    left[i]--;
                    if (left[i] == 0) begin
                        tick_m[i] = 1'b1;
                        if (mod_m[i]) left[i] = (per_m[i] == 0) ? 1 : per_m[i];
                        else act[i] = 0;
                    end
                end
                pend_m[i] = tick_m[i] | (pend_m[i] & ~cl[i]);
            end
            run_m[i] = act[i];
        end
        irq_m = |pend_m;
    endtask

    // Apply one cycle of inputs, clock it, update model, compare outputs.
    task automatic cyc(input bit r, input logic [N-1:0] st, input logic [N-1:0] sp,
                       input logic [N-1:0] md, input logic [N*W-1:0] per,
                       input bit pz, input logic [N-1:0] cl);
        rst = r;
        bus.start = st; bus.stop = sp; bus.mode = md;
        bus.period = per; bus.pause = pz; bus.clr_pending = cl;
        @(posedge clk);
        model_step(r, st, sp, md, per, pz, cl);
        #1;
        chk("tick",    32'(bus.tick),    32'(tick_m));
        chk("running", 32'(bus.running), 32'(run_m));
        chk("pending", 32'(bus.pending), 32'(pend_m));
        chk("irq",     32'(bus.irq),     32'(irq_m));
    endtask

    function automatic logic [N*W-1:0] per_all(input int v);
        return {N{W'(v)}};
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, '0, '0, '0, per_all(0), 0, '0);
    endtask

    initial begin
        logic [N*W-1:0] per;
        logic [N-1:0]   st, sp, md, cl;
        bit             pz, r;

        // Reset: everything low.
        cyc(1, '0, '0, '0, per_all(0), 0, '0);
        cyc(1, '0, '0, '0, per_all(0), 0, '0);
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_irq",  32'(bus.irq),  0);

        // Periodic ch0, period 5: ticks 5, 10, 15 cycles after start.
        cyc(0, 4'b0001, '0, 4'b0001, per_all(5), 0, '0);
        for (int k = 1; k <= 16; k++) begin
            cyc(0, '0, '0, '0, per_all(0), 0, '0);
            chk("p5_tick0", 32'(bus.tick[0]), 32'(k % 5 == 0));
            chk("p5_run0",  32'(bus.running[0]), 1);
        end
        cyc(0, '0, 4'b0001, '0, per_all(0), 0, 4'b0001);

        // One-shot ch1, period 3, then clear pending.
        cyc(0, 4'b0010, '0, '0, per_all(3), 0, '0);
        idle(5);
        chk("os_pend1", 32'(bus.pending[1]), 1);
        chk("os_irq",   32'(bus.irq), 1);
        cyc(0, '0, '0, '0, per_all(0), 0, 4'b0010);
        chk("os_clr", 32'(bus.pending[1]), 0);

        // Periodic 4 on ch2 with a 3-cycle pause mid-count.
        cyc(0, 4'b0100, '0, 4'b0100, per_all(4), 0, '0);
        idle(2);
        for (int k = 0; k < 3; k++) cyc(0, '0, '0, '0, per_all(0), 1, '0);
        idle(6);

        // Stop+start together while running; then restart at counter==0.
        cyc(0, 4'b0100, 4'b0100, 4'b0100, per_all(4), 0, '0);
        chk("ss_run2", 32'(bus.running[2]), 0);
        cyc(0, 4'b0100, '0, 4'b0100, per_all(4), 0, '0);
        idle(3);
        cyc(0, 4'b0100, '0, 4'b0100, per_all(4), 0, '0);
        chk("rs_tick2", 32'(bus.tick[2]), 0);
        idle(5);

        // Period 0 and 1 periodic: tick every cycle; tick beats clear.
        cyc(0, 4'b1001, 4'b0110, 4'b1001, {W'(1), W'(0), W'(0), W'(0)}, 0, 4'b1111);
        for (int k = 0; k < 4; k++) begin
            cyc(0, '0, '0, '0, per_all(0), 0, 4'b1001);
            chk("p01_tick", 32'(bus.tick & 4'b1001), 32'h9);
            chk("p01_pend", 32'(bus.pending & 4'b1001), 32'h9);
        end

        // Reset mid-count on all channels.
        cyc(0, 4'b1111, '0, 4'b1111, per_all(6), 0, '0);
        idle(2);
        cyc(1, '0, '0, '0, per_all(0), 0, '0);
        chk("mrst_run", 32'(bus.running), 0);
        idle(8);
        chk("mrst_tick", 32'(bus.tick), 0);

        // Random stimulus.
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            pz = ($urandom_range(0, 7) == 0);
            st = '0; sp = '0; cl = '0;
            md = N'($urandom);
            for (int i = 0; i < N; i++) begin
                st[i] = ($urandom_range(0, 15) == 0);
                sp[i] = ($urandom_range(0, 39) == 0);
                cl[i] = ($urandom_range(0, 3) == 0);
                per[i*W +: W] = ($urandom_range(0, 19) == 0) ? W'($urandom)
                                                              : W'($urandom_range(0, 9));
            end
            cyc(r, st, sp, md, per, pz, cl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
